// File: rtl/clock_switch_seq_pkg.sv
// Shared types, constants and default timing for the video clock switch sequencer.
// Sizing helpers keep every counter at least one bit wide.
package clock_switch_seq_pkg;

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_HOLD     = 3'd1,
    ST_MRST     = 3'd2,
    ST_LOCKWAIT = 3'd3,
    ST_SETTLE   = 3'd4,
    ST_FAIL     = 3'd5
  } state_e;

  localparam logic [1:0] CHIP6567R8 = 2'd0;
  localparam logic [1:0] CHIP6569   = 2'd1;

  localparam int DEF_DEBOUNCE_CYCLES = 65536;
  localparam int DEF_HOLD_CYCLES     = 64;
  localparam int DEF_MMCM_RST_CYCLES = 16;
  localparam int DEF_LOCK_TIMEOUT    = 1048576;
  localparam int DEF_SETTLE_CYCLES   = 256;
  localparam int DEF_MAX_RETRY       = 3;

  // Registered outputs, updated together from the next state.
  typedef struct packed {
    logic clk_sel;
    logic mmcm_rst;
    logic rst_core;
    logic busy;
    logic lock_fail;
  } seq_out_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/clock_switch_seq_if.sv
// Strap/lock inputs and clock-control outputs of the sequencer.
// master is the sequencer side, slave is the board/consumer side.
interface clock_switch_seq_if;
  logic       is_pal;
  logic       locked;
  logic       clk_sel;
  logic       mmcm_rst;
  logic       rst_core;
  logic [1:0] chip;
  logic       busy;
  logic       lock_fail;

  modport master (
    input  is_pal, locked,
    output clk_sel, mmcm_rst, rst_core, chip, busy, lock_fail
  );

  modport slave (
    output is_pal, locked,
    input  clk_sel, mmcm_rst, rst_core, chip, busy, lock_fail
  );
endinterface

// File: rtl/clock_switch_seq_sync_debounce.sv
// 2-flop synchroniser plus debounce: the accepted value only follows the
// synchronised input after DEBOUNCE_CYCLES consecutive cycles of disagreement.
module clock_switch_seq_sync_debounce
  import clock_switch_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic acc_o,
  output logic chg_o
);
  localparam int             CW       = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q, s2_q;
  logic          acc_q, acc_d;
  logic          chg_q, chg_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    acc_d = acc_q;
    chg_d = 1'b0;
    cnt_d = '0;
    if (s2_q != acc_q) begin
      if (cnt_q == CNT_LAST) begin
        acc_d = s2_q;
        chg_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Reset loads the raw strap everywhere so no spurious change follows reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q  <= d_i;
      s2_q  <= d_i;
      acc_q <= d_i;
      chg_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= d_i;
      s2_q  <= s1_q;
      acc_q <= acc_d;
      chg_q <= chg_d;
      cnt_q <= cnt_d;
    end
  end

  assign acc_o = acc_q;
  assign chg_o = chg_q;

endmodule

// File: rtl/clock_switch_seq.sv
// Video clock sequencer: owns PAL/NTSC source select, MMCM reset and core reset,
// and re-sequences the clock tree on power-up, standard change or loss of lock.
module clock_switch_seq
  import clock_switch_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int MMCM_RST_CYCLES = DEF_MMCM_RST_CYCLES,
  parameter int LOCK_TIMEOUT    = DEF_LOCK_TIMEOUT,
  parameter int SETTLE_CYCLES   = DEF_SETTLE_CYCLES,
  parameter int MAX_RETRY       = DEF_MAX_RETRY
) (
  input  logic                sys_clock,
  input  logic                rst,
  clock_switch_seq_if.master  bus
);
  localparam int TMAX = max2(max2(HOLD_CYCLES, MMCM_RST_CYCLES),
                             max2(LOCK_TIMEOUT, SETTLE_CYCLES));
  localparam int TW   = cnt_w(TMAX);
  localparam int RW   = cnt_w(MAX_RETRY + 1);

  localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] MRST_LAST   = TW'(MMCM_RST_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LAST   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LAST  = RW'(MAX_RETRY - 1);

  logic          pal_acc, pal_chg;
  logic          lock_s1_q, lock_s_q;
  state_e        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          sel_d;
  seq_out_t      out_q, out_d;

  clock_switch_seq_sync_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_pal (
    .clk   (sys_clock),
    .rst   (rst),
    .d_i   (bus.is_pal),
    .acc_o (pal_acc),
    .chg_o (pal_chg)
  );

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    retry_d = retry_q;
    sel_d   = out_q.clk_sel;
    unique case (state_q)
      ST_RUN: begin
        if ((pal_acc != out_q.clk_sel) || !lock_s_q) begin
          state_d = ST_HOLD;
          tmr_d   = '0;
        end
      end
      ST_HOLD: begin
        if (tmr_q == HOLD_LAST) begin
          state_d = ST_MRST;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_MRST: begin
        if (tmr_q == MRST_LAST) begin
          state_d = ST_LOCKWAIT;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_LOCKWAIT: begin
        // The lock sample that leaves LOCKWAIT is the first of the settle run.
        if (lock_s_q) begin
          state_d = ST_SETTLE;
          tmr_d   = TW'(1);
        end else if (tmr_q == LOCK_LAST) begin
          tmr_d   = '0;
          retry_d = retry_q + 1'b1;
          state_d = (retry_q == RETRY_LAST) ? ST_FAIL : ST_MRST;
        end else if (tmr_q != '1) begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_SETTLE: begin
        if (!lock_s_q) begin
          state_d = ST_LOCKWAIT;
          tmr_d   = '0;
        end else if (tmr_q == SETTLE_LAST) begin
          state_d = ST_RUN;
          tmr_d   = '0;
          retry_d = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_FAIL: begin
        if (pal_chg) begin
          state_d = ST_MRST;
          tmr_d   = '0;
          retry_d = '0;
        end
      end
      default: begin
        state_d = ST_MRST;
        tmr_d   = '0;
      end
    endcase
    // The new target is taken only as MRST is entered, so a strap change
    // mid-sequence is picked up by the next pass through RUN.
    if ((state_d == ST_MRST) && (state_q != ST_MRST)) sel_d = pal_acc;
  end

  always_comb begin
    out_d           = '0;
    out_d.clk_sel   = sel_d;
    out_d.mmcm_rst  = (state_d == ST_MRST);
    out_d.rst_core  = (state_d != ST_RUN);
    out_d.busy      = (state_d != ST_RUN);
    out_d.lock_fail = (state_d == ST_FAIL);
  end

  always_ff @(posedge sys_clock) begin
    if (rst) begin
      lock_s1_q <= 1'b0;
      lock_s_q  <= 1'b0;
      state_q   <= ST_MRST;
      tmr_q     <= '0;
      retry_q   <= '0;
      out_q     <= '{clk_sel: bus.is_pal, mmcm_rst: 1'b1, rst_core: 1'b1,
                     busy: 1'b1, lock_fail: 1'b0};
    end else begin
      lock_s1_q <= bus.locked;
      lock_s_q  <= lock_s1_q;
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      retry_q   <= retry_d;
      out_q     <= out_d;
    end
  end

  assign bus.clk_sel   = out_q.clk_sel;
  assign bus.mmcm_rst  = out_q.mmcm_rst;
  assign bus.rst_core  = out_q.rst_core;
  assign bus.busy      = out_q.busy;
  assign bus.lock_fail = out_q.lock_fail;
  assign bus.chip      = out_q.clk_sel ? CHIP6569 : CHIP6567R8;

  // The clock source may only move while the core and the MMCM are held.
  sel_safe_a: assert property (@(posedge sys_clock) disable iff (rst)
    (out_q.clk_sel != $past(out_q.clk_sel)) |-> (out_q.mmcm_rst && out_q.rst_core));

endmodule

// File: tb/tb_clock_switch_seq.sv
// Scenario stimulus with randomised lock/glitch timing; expected output changes
// are derived from the sequencing rules and checked by an independent monitor.
module tb_clock_switch_seq;
  localparam int DEB = 4, HOLD = 8, MRC = 4, TO = 32, SET = 8, RETRY = 2;

  typedef struct {
    int         t;
    logic [6:0] v;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  ev_t  exp_q[$];

  clock_switch_seq_if bus();

  clock_switch_seq #(
    .DEBOUNCE_CYCLES (DEB),
    .HOLD_CYCLES     (HOLD),
    .MMCM_RST_CYCLES (MRC),
    .LOCK_TIMEOUT    (TO),
    .SETTLE_CYCLES   (SET),
    .MAX_RETRY       (RETRY)
  ) dut (
    .sys_clock (clk),
    .rst       (rst),
    .bus       (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected output vector: {lock_fail, busy, rst_core, mmcm_rst, clk_sel, chip}.
  function automatic logic [6:0] mk(input logic lf, input logic b, input logic rc,
                                    input logic mr, input logic cs);
    return {lf, b, rc, mr, cs, 1'b0, cs};
  endfunction

  task automatic push(input int t, input logic lf, input logic b, input logic rc,
                      input logic mr, input logic cs);
    exp_q.push_back('{t: t, v: mk(lf, b, rc, mr, cs)});
  endtask

  // Returns #1 after edge c; inputs changed here are first sampled at edge c+1.
  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // MRST entered at edge m: pulse, relock after random delay, release to RUN.
  task automatic do_seq(input int m, input logic cs, input logic push_entry);
    int d, l;
    if (push_entry) push(m, 0, 1, 1, 1, cs);
    wait_until(m);
    bus.locked = 1'b0;
    push(m + MRC, 0, 1, 1, 0, cs);
    d = int'($urandom_range(0, 20));
    l = m + MRC + d;
    wait_until(l);
    bus.locked = 1'b1;
    push(l + 2 + SET, 0, 0, 0, 0, cs);
    wait_until(l + 2 + SET + 3);
  endtask

  task automatic summary();
    $display("Result: errors=%0d of %0d checks", errors, checks);
  endtask

  // Monitor: every change of the output vector must match the next expected event.
  initial begin
    logic [6:0] prev, cur;
    ev_t        e;
    prev = 'x;
    forever begin
      @(negedge clk);
      cur = {bus.lock_fail, bus.busy, bus.rst_core, bus.mmcm_rst, bus.clk_sel, bus.chip};
      if (cur !== prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change cyc=%0d got=%b required=no change", cyc, cur);
        end else begin
          e = exp_q.pop_front();
          if ((e.t != cyc) || (e.v !== cur)) begin
            errors++;
            $display("FAIL event got cyc=%0d vec=%b required cyc=%0d vec=%b",
                     cyc, cur, e.t, e.v);
          end
        end
        prev = cur;
      end
    end
  end

  initial begin
    #200000;
    errors++;
    checks++;
    $display("FAIL watchdog cyc=%0d required=finish before timeout", cyc);
    summary();
    $finish;
  end

  initial begin
    int c, r, r2, l, t, d, y, e, g;
    rst        = 1'b1;
    bus.is_pal = 1'b1;
    bus.locked = 1'b0;

    // Power-up as PAL.
    push(1, 0, 1, 1, 1, 1);
    wait_until(2);
    rst = 1'b0;
    do_seq(2, 1'b1, 1'b0);

    // Standard change PAL -> NTSC.
    c = cyc + 3;
    wait_until(c);
    bus.is_pal = 1'b0;
    push(c + 2 + DEB + 1, 0, 1, 1, 0, 1);
    do_seq(c + 2 + DEB + 1 + HOLD, 1'b0, 1'b1);

    // Short strap glitch is filtered.
    g = int'($urandom_range(1, DEB - 1));
    c = cyc + 3;
    wait_until(c);
    bus.is_pal = 1'b1;
    wait_until(c + g);
    bus.is_pal = 1'b0;
    wait_until(c + g + 12);
    checks++;
    if (bus.rst_core !== 1'b0) begin
      errors++;
      $display("FAIL glitch_rst_core got=%b required=0", bus.rst_core);
    end

    // Lock never arrives: retries exhaust, then a strap change restarts.
    c = cyc + 2;
    wait_until(c);
    rst = 1'b1;
    bus.locked = 1'b0;
    r = c + 1;
    push(r, 0, 1, 1, 1, 0);
    wait_until(r);
    rst = 1'b0;
    push(r + MRC, 0, 1, 1, 0, 0);
    push(r + MRC + TO, 0, 1, 1, 1, 0);
    push(r + 2 * MRC + TO, 0, 1, 1, 0, 0);
    push(r + 2 * MRC + 2 * TO, 1, 1, 1, 0, 0);
    t = r + 2 * MRC + 2 * TO + 3;
    wait_until(t);
    bus.is_pal = 1'b1;
    do_seq(t + 2 + DEB + 1, 1'b1, 1'b1);

    // One-cycle lock drop in RUN re-sequences with the same source.
    c = cyc + 3;
    wait_until(c);
    bus.locked = 1'b0;
    wait_until(c + 1);
    bus.locked = 1'b1;
    push(c + 3, 0, 1, 1, 0, 1);
    do_seq(c + 3 + HOLD, 1'b1, 1'b1);

    // Lock lost during settle: timer restarts, retry count is kept.
    c = cyc + 2;
    wait_until(c);
    rst = 1'b1;
    bus.locked = 1'b0;
    r = c + 1;
    push(r, 0, 1, 1, 1, 1);
    wait_until(r);
    rst = 1'b0;
    push(r + MRC, 0, 1, 1, 0, 1);
    push(r + MRC + TO, 0, 1, 1, 1, 1);
    push(r + 2 * MRC + TO, 0, 1, 1, 0, 1);
    d = int'($urandom_range(0, 15));
    l = r + 2 * MRC + TO + d;
    wait_until(l);
    bus.locked = 1'b1;
    y = int'($urandom_range(1, SET - 1));
    wait_until(l + y);
    bus.locked = 1'b0;
    push(l + y + 3 + TO, 1, 1, 1, 0, 1);
    wait_until(l + y + 3 + TO + 3);

    // Reset inside LOCKWAIT clears the retry count.
    c = cyc + 2;
    wait_until(c);
    rst = 1'b1;
    r = c + 1;
    push(r, 0, 1, 1, 1, 1);
    wait_until(r);
    rst = 1'b0;
    push(r + MRC, 0, 1, 1, 0, 1);
    push(r + MRC + TO, 0, 1, 1, 1, 1);
    push(r + 2 * MRC + TO, 0, 1, 1, 0, 1);
    e = int'($urandom_range(1, 20));
    c = r + 2 * MRC + TO + e;
    wait_until(c);
    rst = 1'b1;
    r2 = c + 1;
    push(r2, 0, 1, 1, 1, 1);
    wait_until(r2);
    rst = 1'b0;
    push(r2 + MRC, 0, 1, 1, 0, 1);
    do_seq(r2 + MRC + TO, 1'b1, 1'b1);

    wait_until(cyc + 5);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events got=%0d required=0 next_cyc=%0d",
               exp_q.size(), exp_q[0].t);
    end
    summary();
    $finish;
  end

endmodule
